// File: rtl/pixel_depth_writer_pkg.sv
// Shared types for the pixel write path: pixel formats, depth limits and writer states.
// Imported by the writer, its address generator and the pixel/framebuffer interface.
package pixel_depth_writer_pkg;

    localparam int COLOR_W = 8;
    localparam int DEPTH_W = 16;
    localparam int COORD_W = 10;

    localparam logic [DEPTH_W-1:0] MAX_DEPTH = '1;

    typedef struct packed {
        logic [COLOR_W-1:0] red;
        logic [COLOR_W-1:0] green;
        logic [COLOR_W-1:0] blue;
        logic [DEPTH_W-1:0] depth;
    } pixel_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        pixel_t             pixel;
    } pixel_info_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CMP,
        ST_WR,
        ST_CLR
    } writer_state_t;

    // Background fill used by the clear sweep: farthest possible depth so any fragment wins.
    function automatic pixel_t clear_pixel(input logic [COLOR_W-1:0] bg);
        pixel_t p;
        p.red   = bg;
        p.green = bg;
        p.blue  = bg;
        p.depth = MAX_DEPTH;
        return p;
    endfunction

endpackage

// File: rtl/pixel_depth_writer_if.sv
// Pixel write handshake plus single-port framebuffer bus.
// The slave modport is the depth writer; the master modport is the rasterizer/SRAM side.
interface pixel_depth_writer_if #(
    parameter int ADDR_W = 19
);
    import pixel_depth_writer_pkg::*;

    logic              data_write;
    pixel_info_t       data_in;
    logic              output_written;
    logic              clear_start;
    logic              clear_done;
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_read;
    pixel_t            fb_rdata;
    logic              fb_write;
    pixel_t            fb_wdata;

    modport master (
        output data_write, data_in, clear_start, fb_rdata,
        input  output_written, clear_done, fb_addr, fb_read, fb_write, fb_wdata
    );

    modport slave (
        input  data_write, data_in, clear_start, fb_rdata,
        output output_written, clear_done, fb_addr, fb_read, fb_write, fb_wdata
    );

endinterface

// File: rtl/pixel_depth_writer_addr_gen.sv
// Linear framebuffer address y*WIDTH + x: combinational result plus a copy registered on load.
// Kept standalone so the display scanout can reuse it.
module fb_addr_gen
    import pixel_depth_writer_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int ADDR_W = 19
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [ADDR_W-1:0]  addr_reg_o
);

    logic [ADDR_W-1:0] addr_q;

    always_comb begin
        addr_o = ADDR_W'(y_i) * ADDR_W'(WIDTH) + ADDR_W'(x_i);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else if (load_i) begin
            addr_q <= addr_o;
        end
    end

    assign addr_reg_o = addr_q;

endmodule

// File: rtl/pixel_depth_writer.sv
// Depth-tested pixel writer in front of a single-port framebuffer SRAM, with a full-frame clear.
// Every output is a flop loaded from the next-state decode, so strobes line up with the state.
module pixel_depth_writer
    import pixel_depth_writer_pkg::*;
#(
    parameter int                 WIDTH    = 640,
    parameter int                 HEIGHT   = 480,
    parameter int                 ADDR_W   = 19,
    parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    pixel_depth_writer_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    writer_state_t     state_q, state_d;
    logic              pending_q, pending_d;
    pixel_t            pix_q, pix_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d;
    pixel_t            wdata_q, wdata_d;

    logic              accept;
    logic              in_range;
    logic [ADDR_W-1:0] addr_comb;
    logic [ADDR_W-1:0] addr_reg;

    // A coincident clear request takes priority over the offered pixel.
    assign accept   = bus.data_write && ready_q && !bus.clear_start;
    assign in_range = (int'(bus.data_in.x) < WIDTH) && (int'(bus.data_in.y) < HEIGHT);

    fb_addr_gen #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clock      (clock),
        .reset      (reset),
        .load_i     (accept),
        .x_i        (bus.data_in.x),
        .y_i        (bus.data_in.y),
        .addr_o     (addr_comb),
        .addr_reg_o (addr_reg)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        pending_d  = pending_q;
        pix_d      = pix_q;
        clr_cnt_d  = clr_cnt_q;
        done_d     = 1'b0;
        addr_out_d = '0;
        wdata_d    = '0;

        if (bus.clear_start && (state_q inside {ST_RD, ST_CMP, ST_WR})) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.clear_start || pending_q) begin
                    state_d   = ST_CLR;
                    pending_d = 1'b0;
                    clr_cnt_d = '0;
                end else if (accept) begin
                    pix_d = bus.data_in.pixel;
                    if (in_range) begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD:  state_d = ST_CMP;
            ST_CMP: state_d = (pix_q.depth < bus.fb_rdata.depth) ? ST_WR : ST_IDLE;
            ST_WR:  state_d = ST_IDLE;
            ST_CLR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rd_d    = (state_d == ST_RD);
        wr_d    = (state_d == ST_WR) || (state_d == ST_CLR);
        ready_d = (state_d == ST_IDLE) && !pending_d;

        // RD is only entered from IDLE, where the live address is the one being accepted.
        unique case (state_d)
            ST_RD:  addr_out_d = addr_comb;
            ST_WR: begin
                addr_out_d = addr_reg;
                wdata_d    = pix_q;
            end
            ST_CLR: begin
                addr_out_d = clr_cnt_d;
                wdata_d    = clear_pixel(BG_COLOR);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            pix_q      <= '0;
            clr_cnt_q  <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_out_q <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            pix_q      <= pix_d;
            clr_cnt_q  <= clr_cnt_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_out_q <= addr_out_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.output_written = ready_q;
    assign bus.clear_done     = done_q;
    assign bus.fb_read        = rd_q;
    assign bus.fb_write       = wr_q;
    assign bus.fb_addr        = addr_out_q;
    assign bus.fb_wdata       = wdata_q;

endmodule

// File: tb/tb_pixel_depth_writer.sv
// Directed bench for pixel_depth_writer on an 8x4 frame with a behavioural single-port SRAM.
module tb_pixel_depth_writer;
    import pixel_depth_writer_pkg::*;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   wr_cnt;
    int   done_cnt;

    pixel_t mem [W*H];
    pixel_t clr_pix;
    pixel_t exp_pix;

    pixel_depth_writer_if #(.ADDR_W(AW)) bus ();

    pixel_depth_writer #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .ADDR_W   (AW),
        .BG_COLOR (8'h00)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.fb_write) begin
            mem[bus.fb_addr] <= bus.fb_wdata;
            wr_cnt           <= wr_cnt + 1;
        end
        if (bus.fb_read) begin
            bus.fb_rdata <= mem[bus.fb_addr];
        end
        if (bus.clear_done) begin
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one in-range pixel and walks it through RD/CMP/(WR) checking strobes per cycle.
    task automatic do_pixel(input string tag, input int x, input int y, input logic [7:0] r,
                            input logic [7:0] g, input logic [7:0] b, input logic [15:0] d,
                            input bit win, input int exp_addr);
        pixel_t p;
        p.red = r; p.green = g; p.blue = b; p.depth = d;
        bus.data_in.x     = 10'(x);
        bus.data_in.y     = 10'(y);
        bus.data_in.pixel = p;
        bus.data_write    = 1'b1;
        check({tag, "_ready_pre"}, 64'(bus.output_written), 64'd1);
        tick();
        bus.data_write = 1'b0;
        check({tag, "_rd_strobes"}, 64'({bus.fb_read, bus.fb_write, bus.output_written}), 64'b100);
        check({tag, "_rd_addr"}, 64'(bus.fb_addr), 64'(exp_addr));
        tick();
        check({tag, "_cmp_strobes"}, 64'({bus.fb_read, bus.fb_write, bus.output_written}), 64'b000);
        tick();
        if (win) begin
            check({tag, "_wr_strobes"}, 64'({bus.fb_read, bus.fb_write, bus.output_written}), 64'b010);
            check({tag, "_wr_addr"}, 64'(bus.fb_addr), 64'(exp_addr));
            check({tag, "_wr_data"}, 64'(bus.fb_wdata), 64'(p));
            tick();
        end
        check({tag, "_ready_back"}, 64'({bus.fb_read, bus.fb_write, bus.output_written}), 64'b001);
    endtask

    initial begin
        int wr_before;
        int done_before;

        checks   = 0;
        errors   = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        clr_pix  = '{red: 8'h00, green: 8'h00, blue: 8'h00, depth: 16'hFFFF};

        bus.data_write  = 1'b0;
        bus.data_in     = '0;
        bus.clear_start = 1'b0;
        rst             = 1'b1;
        tick();
        tick();
        check("rst_ready", 64'(bus.output_written), 64'd1);
        check("rst_strobes", 64'({bus.clear_done, bus.fb_read, bus.fb_write}), 64'b000);
        check("rst_addr", 64'(bus.fb_addr), 64'd0);
        check("rst_wdata", 64'(bus.fb_wdata), 64'd0);
        rst = 1'b0;
        tick();

        // 1: full clear sweep
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        for (int i = 0; i < W*H; i++) begin
            check("clr_strobes", 64'({bus.fb_write, bus.fb_read, bus.output_written, bus.clear_done}), 64'b1000);
            check("clr_addr", 64'(bus.fb_addr), 64'(i));
            check("clr_wdata", 64'(bus.fb_wdata), 64'(clr_pix));
            tick();
        end
        check("clr_done_pulse", 64'({bus.clear_done, bus.output_written, bus.fb_write}), 64'b110);
        tick();
        check("clr_done_drop", 64'(bus.clear_done), 64'd0);
        check("clr_mem_last", 64'(mem[W*H-1]), 64'(clr_pix));

        // 2: winning write at (3,2) -> address 19
        do_pixel("win", 3, 2, 8'd5, 8'd6, 8'd7, 16'd10, 1'b1, 19);
        exp_pix = '{red: 8'd5, green: 8'd6, blue: 8'd7, depth: 16'd10};
        check("win_mem", 64'(mem[19]), 64'(exp_pix));

        // 3: farther and equal depth both lose
        wr_before = wr_cnt;
        do_pixel("lose", 3, 2, 8'd9, 8'd9, 8'd9, 16'd12, 1'b0, 19);
        do_pixel("tie", 3, 2, 8'd8, 8'd8, 8'd8, 16'd10, 1'b0, 19);
        check("lose_tie_no_write", 64'(wr_cnt - wr_before), 64'd0);
        check("lose_tie_mem", 64'(mem[19]), 64'(exp_pix));

        // 4: out-of-range pixel dropped; next pixel accepted on the following edge
        wr_before         = wr_cnt;
        bus.data_in.x     = 10'd8;
        bus.data_in.y     = 10'd0;
        bus.data_in.pixel = '{red: 8'd1, green: 8'd1, blue: 8'd1, depth: 16'd1};
        bus.data_write    = 1'b1;
        tick();
        check("oor_strobes", 64'({bus.fb_read, bus.fb_write, bus.output_written}), 64'b001);
        do_pixel("after_oor", 0, 0, 8'd1, 8'd2, 8'd3, 16'd1, 1'b1, 0);
        check("oor_one_write", 64'(wr_cnt - wr_before), 64'd1);

        // 5: clear requested while a pixel is in flight
        bus.data_in.x     = 10'd1;
        bus.data_in.y     = 10'd1;
        bus.data_in.pixel = '{red: 8'd4, green: 8'd4, blue: 8'd4, depth: 16'd3};
        bus.data_write    = 1'b1;
        tick();
        bus.data_write  = 1'b0;
        bus.clear_start = 1'b1;
        check("pend_rd", 64'({bus.fb_read, bus.fb_addr}), 64'({1'b1, 5'd9}));
        tick();
        bus.clear_start = 1'b0;
        tick();
        check("pend_wr", 64'({bus.fb_write, bus.fb_addr}), 64'({1'b1, 5'd9}));
        bus.data_in.x     = 10'd2;
        bus.data_in.y     = 10'd0;
        bus.data_in.pixel = '{red: 8'd7, green: 8'd7, blue: 8'd7, depth: 16'd0};
        bus.data_write    = 1'b1;
        tick();
        check("pend_idle", 64'({bus.output_written, bus.fb_write, bus.fb_read}), 64'b000);
        tick();
        for (int i = 0; i < W*H; i++) begin
            check("pend_clr", 64'({bus.fb_write, bus.output_written, bus.fb_addr}), 64'({1'b1, 1'b0, 5'(i)}));
            tick();
        end
        check("pend_done", 64'({bus.clear_done, bus.output_written, bus.fb_write}), 64'b110);
        tick();
        bus.data_write = 1'b0;
        check("post_clr_rd", 64'({bus.fb_read, bus.fb_addr}), 64'({1'b1, 5'd2}));
        tick();
        tick();
        check("post_clr_wr", 64'({bus.fb_write, bus.fb_addr}), 64'({1'b1, 5'd2}));
        tick();
        check("post_clr_ready", 64'(bus.output_written), 64'd1);

        // 6: reset in the middle of a sweep
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        check("rstclr_addr10", 64'({bus.fb_write, bus.fb_addr}), 64'({1'b1, 5'd10}));
        rst = 1'b1;
        tick();
        check("rstclr_outputs", 64'({bus.output_written, bus.fb_read, bus.fb_write, bus.clear_done}), 64'b1000);
        rst = 1'b0;
        wr_before   = wr_cnt;
        done_before = done_cnt;
        for (int i = 0; i < 40; i++) begin
            tick();
        end
        check("rstclr_no_writes", 64'(wr_cnt - wr_before), 64'd0);
        check("rstclr_no_done", 64'(done_cnt - done_before), 64'd0);
        check("rstclr_ready", 64'(bus.output_written), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_depth_writer.md
# pixel_depth_writer

Sink end of the rasterizer pixel-write handshake. It accepts `pixel_info_t` writes, reads the stored framebuffer pixel, performs a depth test, and writes back only when the new fragment is nearer. It also provides a full-frame clear sweep. One instance sits between the rasterizer output arbiter and the single-port framebuffer SRAM.

## Interface

Parameters:
- `WIDTH`, default 640: horizontal pixels; valid x is 0..WIDTH-1.
- `HEIGHT`, default 480: vertical pixels; valid y is 0..HEIGHT-1.
- `ADDR_W`, default 19: framebuffer address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT.
- `BG_COLOR`, default 0: red/green/blue value written by clear.

Ports:
- `clock`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `data_write`  in  1  `data_in` holds a valid pixel this cycle.
- `data_in`  in  `pixel_info_t`  x[9:0], y[9:0], pixel {red, green, blue, depth}.
- `output_written`  out  1  ready; high when a pixel can be accepted.
- `clear_start`  in  1  request a full-frame clear (single-cycle pulse).
- `clear_done`  out  1  one-cycle pulse when the clear sweep finishes.
- `fb_addr`  out  ADDR_W  SRAM address.
- `fb_read`  out  1  read strobe; `fb_rdata` is valid exactly 1 cycle later.
- `fb_rdata`  in  `pixel_t`  stored pixel.
- `fb_write`  out  1  write strobe.
- `fb_wdata`  out  `pixel_t`  write data.

## Operation

- **Accept rule:** a pixel is accepted on each rising edge where `data_write && output_written`. The source must hold `data_in` stable while `data_write` is high and `output_written` is low.
- **Address:** `addr = y*WIDTH + x`, computed at accept and registered. Evaluate the product in ADDR_W bits; it never overflows for in-range coordinates.
- **States:**
  - IDLE: `output_written=1`. On accept, latch the pixel and address. If x ≥ WIDTH or y ≥ HEIGHT, drop the pixel and stay in IDLE; ready remains high. Otherwise go to RD.
  - RD: `fb_read=1`, `fb_addr=addr` → CMP.
  - CMP: `fb_rdata` is valid. If `new.depth < stored.depth` (unsigned) → WR; else → IDLE. Equal depth means the stored pixel is kept.
  - WR: `fb_write=1`, `fb_addr=addr`, `fb_wdata` = latched pixel → IDLE.
  - CLR: `fb_write=1`, `fb_addr` = counter, `fb_wdata` = {BG_COLOR ×3, depth all-ones}. Counter runs 0..WIDTH*HEIGHT-1, +1 per cycle. After the last address → IDLE with `clear_done=1` for one cycle.
- **Clear entry:**
  - `clear_start` in IDLE → CLR next cycle.
  - `clear_start` while in RD/CMP/WR is latched as pending; CLR is entered from IDLE immediately after the in-flight pixel retires.
  - When clear is pending or active, `output_written=0`.
  - If `clear_start` and an accept coincide in IDLE, clear wins and the pixel is not accepted.
  - `clear_start` during CLR is ignored.
- **Reset** (any time, including mid-clear or mid-pixel): go to IDLE; the sweep aborts without a `clear_done`.
- **Reset values:** `output_written=1`, `clear_done=0`, `fb_read=0`, `fb_write=0`, `fb_addr=0`, `fb_wdata=0`; pending-clear flag 0.
- `fb_read` and `fb_write` are never high in the same cycle.

## Timing

- All outputs are registered.
- Accept at edge N:
  - `output_written` low from N+1.
  - `fb_read` high in cycle N+1.
  - Compare in N+2.
  - Winning write: `fb_write` in N+3; `output_written` high again at N+4.
  - Losing pixel: `output_written` high again at N+3.
- Throughput: one pixel per 4 cycles (win) or 3 cycles (lose).
- Dropped out-of-range pixel: `output_written` never drops; the next pixel can be accepted at N+1.
- Clear: WIDTH*HEIGHT write cycles, then `clear_done` in the cycle after the last write. At defaults: 307200 writes.

## Structure

- Add `pixel_t`, `pixel_info_t` (if not already present), `MAX_DEPTH`, and the `writer_state_t` enum to `common`.
- One sub-module, `fb_addr_gen`: combinational y*WIDTH+x with a registered output, reusable by the display scanout.
- Target 150–250 lines.

## Test plan

1. Clear with WIDTH=8, HEIGHT=4 → 32 consecutive `fb_write` at addresses 0..31 with depth 0xFF.., then one `clear_done` pulse.
2. Cleared frame; write (x=3, y=2, rgb=5/6/7, depth=10) → `fb_read` at addr 19, then `fb_write` at addr 19 with that data; ready returns 4 cycles after accept.
3. Same location, depth 10 then depth 12 then depth 10 → only the first writes; the second and third produce no `fb_write` (lose/tie); ready returns after 3 cycles each.
4. Pixel at x=8, y=0 (out of range) → no SRAM access; `output_written` stays 1.
5. `clear_start` one cycle after accepting a pixel → pixel completes (RD/CMP/WR), then the sweep starts; `data_write` held during the sweep is not accepted until after `clear_done`.
6. Assert `reset` at sweep address 10 → all strobes 0 and `output_written=1` the following cycle; no `clear_done`.
